ptw_arbiter: RTL and testbench

PTW_ARBITER -- requirements
Module: ptw_arbiter

---
 rtl/ptw_pkg.sv | 30 +++
 rtl/ptw_req_slot.sv | 47 ++++
 rtl/ptw_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ptw_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_pkg.sv
// ptw_pkg -- shared types and constants for the page-table-walk arbiter.
//   state_t  : arbiter FSM encoding (DRAIN exists only with PTW_TIMEOUT_EN)
//   req_id_t : requester identifiers (ITLB = 0, DTLB = 1)
//   DEFAULT_TIMEOUT_CYCLES : default response timeout in clock cycles
// Configuration macro: PTW_TIMEOUT_EN (adds the DRAIN state).
package ptw_pkg;

`ifdef PTW_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;
`endif

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ptw_req_slot.sv
// ptw_req_slot -- one pending-request slot (valid bit + captured address).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request pulse; sets the slot and captures req_addr
//   req_addr    : PTE address accompanying the pulse
//   flush       : clears the slot; a coincident request pulse is discarded
//   grant       : arbiter took the slot this cycle; clears it
//   pending     : slot holds an un-issued request
//   addr        : captured address
module ptw_req_slot
    import ptw_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,
    input  logic                  grant,
    output logic                  pending,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic                  pending_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;

    // A new pulse wins over a same-cycle grant: the grant consumes the old
    // address, and the new request stays pending behind the in-flight one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            addr_reg    <= '0;
        end else if (flush) begin
            pending_reg <= 1'b0;
        end else if (req_valid) begin
            pending_reg <= 1'b1;
            addr_reg    <= req_addr;
        end else if (grant) begin
            pending_reg <= 1'b0;
        end
    end

    assign pending = pending_reg;
    assign addr    = addr_reg;

endmodule

// File: rtl/ptw_arbiter.sv
// ptw_arbiter -- arbitrates ITLB/DTLB page-table-walk reads onto one AXI master.
// Ports:
//   CLK, RSTN                 : clock, asynchronous active-low reset
//   I_REQ_VALID/I_REQ_ADDR    : ITLB request pulse and PTE address
//   I_RESP_VALID/I_ACCESS_FAULT : ITLB response pulse / timeout pulse
//   D_*                       : same set for the DTLB
//   RESP_DATA                 : M_DATA broadcast to both TLBs
//   M_ADDR_VALID/M_ADDR/M_ADDR_READY : address handshake to the AXI master
//   M_DATA_VALID/M_DATA       : PTE return from the AXI master
//   FLUSH                     : TLB flush (clears slots, drops in-flight reply)
//   BUSY                      : not IDLE or any slot pending
// Configuration macro: PTW_TIMEOUT_EN enables the response timeout and DRAIN.
module ptw_arbiter
    import ptw_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  I_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] I_REQ_ADDR,
    output logic                  I_RESP_VALID,
    output logic                  I_ACCESS_FAULT,
    input  logic                  D_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] D_REQ_ADDR,
    output logic                  D_RESP_VALID,
    output logic                  D_ACCESS_FAULT,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic                  M_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic                  M_ADDR_READY,
    input  logic                  M_DATA_VALID,
    input  logic [DATA_WIDTH-1:0] M_DATA,
    input  logic                  FLUSH,
    output logic                  BUSY
);

    state_t                state_reg, state_next;
    req_id_t               owner_reg, owner_next;
    req_id_t               prio_reg, prio_next;   // requester favoured on a tie
    logic                  drop_reg, drop_next;
    logic [ADDR_WIDTH-1:0] maddr_reg, maddr_next;
    req_id_t               grant_id;
    logic                  grant_i, grant_d;
    logic                  i_pend, d_pend;
    logic [ADDR_WIDTH-1:0] i_addr, d_addr;
    logic                  resp_fire, fault_fire;

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_i (
        .clk       (CLK),
        .rst_n     (RSTN),
        .req_valid (I_REQ_VALID),
        .req_addr  (I_REQ_ADDR),
        .flush     (FLUSH),
        .grant     (grant_i),
        .pending   (i_pend),
        .addr      (i_addr)
    );

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_d (
        .clk       (CLK),
        .rst_n     (RSTN),
        .req_valid (D_REQ_VALID),
        .req_addr  (D_REQ_ADDR),
        .flush     (FLUSH),
        .grant     (grant_d),
        .pending   (d_pend),
        .addr      (d_addr)
    );

`ifdef PTW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    // The priority pointer holds the requester to favour next, i.e. the one
    // not granted last; resetting it to ITLB gives ITLB the first tie.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        prio_next  = prio_reg;
        drop_next  = drop_reg;
        maddr_next = maddr_reg;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        resp_fire  = 1'b0;
        fault_fire = 1'b0;
        grant_id   = (i_pend && d_pend) ? prio_reg : (i_pend ? REQ_I : REQ_D);
`ifdef PTW_TIMEOUT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                drop_next = 1'b0;
                if (i_pend || d_pend) begin
                    state_next = ISSUE;
                    owner_next = grant_id;
                    maddr_next = (grant_id == REQ_I) ? i_addr : d_addr;
                    grant_i    = (grant_id == REQ_I);
                    grant_d    = (grant_id == REQ_D);
                end
            end
            ISSUE: begin
                if (FLUSH) drop_next = 1'b1;
                if (M_ADDR_READY) begin
                    state_next = WAIT;
`ifdef PTW_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end
            end
            WAIT: begin
                if (FLUSH) drop_next = 1'b1;
                if (M_DATA_VALID) begin
                    // A flush in the response cycle also suppresses forwarding.
                    resp_fire  = !drop_reg && !FLUSH;
                    state_next = IDLE;
                    prio_next  = (owner_reg == REQ_I) ? REQ_D : REQ_I;
                end
`ifdef PTW_TIMEOUT_EN
                else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Last WAIT cycle of the budget: fault now, drain the reply.
                    fault_fire = !drop_reg && !FLUSH;
                    state_next = DRAIN;
                    prio_next  = (owner_reg == REQ_I) ? REQ_D : REQ_I;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
`ifdef PTW_TIMEOUT_EN
            DRAIN: begin
                if (M_DATA_VALID) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= IDLE;
            owner_reg <= REQ_I;
            prio_reg  <= REQ_I;
            drop_reg  <= 1'b0;
            maddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            prio_reg  <= prio_next;
            drop_reg  <= drop_next;
            maddr_reg <= maddr_next;
        end
    end

`ifdef PTW_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
    end
    assign I_ACCESS_FAULT = fault_fire && (owner_reg == REQ_I);
    assign D_ACCESS_FAULT = fault_fire && (owner_reg == REQ_D);
`else
    assign I_ACCESS_FAULT = 1'b0;
    assign D_ACCESS_FAULT = 1'b0;
`endif

    assign I_RESP_VALID = resp_fire && (owner_reg == REQ_I);
    assign D_RESP_VALID = resp_fire && (owner_reg == REQ_D);
    assign RESP_DATA    = M_DATA;
    assign M_ADDR_VALID = (state_reg == ISSUE);
    assign M_ADDR       = maddr_reg;
    assign BUSY         = (state_reg != IDLE) || i_pend || d_pend;

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter -- directed self-checking bench for ptw_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Build with +define+PTW_TIMEOUT_EN to cover the timeout path.
module tb_ptw_arbiter;

    logic        clk;
    logic        rstn;
    logic        i_req_valid, d_req_valid;
    logic [63:0] i_req_addr, d_req_addr;
    logic        i_resp_valid, d_resp_valid;
    logic        i_access_fault, d_access_fault;
    logic [63:0] resp_data;
    logic        m_addr_valid, m_addr_ready;
    logic [63:0] m_addr;
    logic        m_data_valid;
    logic [63:0] m_data;
    logic        flush, busy;

    int n_cmp = 0;
    int n_err = 0;

    ptw_arbiter #(
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK            (clk),
        .RSTN           (rstn),
        .I_REQ_VALID    (i_req_valid),
        .I_REQ_ADDR     (i_req_addr),
        .I_RESP_VALID   (i_resp_valid),
        .I_ACCESS_FAULT (i_access_fault),
        .D_REQ_VALID    (d_req_valid),
        .D_REQ_ADDR     (d_req_addr),
        .D_RESP_VALID   (d_resp_valid),
        .D_ACCESS_FAULT (d_access_fault),
        .RESP_DATA      (resp_data),
        .M_ADDR_VALID   (m_addr_valid),
        .M_ADDR         (m_addr),
        .M_ADDR_READY   (m_addr_ready),
        .M_DATA_VALID   (m_data_valid),
        .M_DATA         (m_data),
        .FLUSH          (flush),
        .BUSY           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request/flush pulse; starts and ends at the start of a cycle.
    task automatic pulse(input logic pi, input logic pd, input logic [63:0] ai,
                         input logic [63:0] ad, input logic fl);
        i_req_valid = pi;
        d_req_valid = pd;
        i_req_addr  = ai;
        d_req_addr  = ad;
        flush       = fl;
        cyc();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        flush       = 1'b0;
    endtask

    // Wait (bounded) for M_ADDR_VALID; returns the number of whole cycles
    // waited. Ends at the falling edge of the first ISSUE cycle.
    task automatic wait_issue(input logic [63:0] exp_addr, output int waited);
        int k;
        k = 0;
        @(negedge clk);
        while (!m_addr_valid && k < 20) begin
            cyc();
            @(negedge clk);
            k++;
        end
        waited = k;
        check_val("issue_valid", m_addr_valid, 1'b1);
        check_val("issue_addr", m_addr, exp_addr);
    endtask

    // Hold READY low for ready_lo cycles, then handshake. Starts at the
    // falling edge of the first ISSUE cycle, ends at the start of WAIT.
    task automatic do_handshake(input int ready_lo, input logic [63:0] exp_addr);
        for (int r = 0; r < ready_lo; r++) begin
            check_val("hold_valid", m_addr_valid, 1'b1);
            check_val("hold_addr", m_addr, exp_addr);
            cyc();
            @(negedge clk);
        end
        check_val("hs_valid", m_addr_valid, 1'b1);
        check_val("hs_addr", m_addr, exp_addr);
        m_addr_ready = 1'b1;
        cyc();
        m_addr_ready = 1'b0;
    endtask

    // Return data dly cycles after the handshake cycle and check routing.
    task automatic respond(input int dly, input logic [63:0] data,
                           input logic exp_i, input logic exp_d);
        for (int w = 0; w < dly - 1; w++) begin
            @(negedge clk);
            check_val("wait_avalid", m_addr_valid, 1'b0);
            check_val("wait_resp", {i_resp_valid, d_resp_valid}, 2'b00);
            cyc();
        end
        m_data_valid = 1'b1;
        m_data       = data;
        @(negedge clk);
        check_val("resp_i", i_resp_valid, exp_i);
        check_val("resp_d", d_resp_valid, exp_d);
        check_val("resp_fault", {i_access_fault, d_access_fault}, 2'b00);
        if (exp_i || exp_d) check_val("resp_data", resp_data, data);
        $display("txn: resp i=%0b d=%0b data=%h", i_resp_valid, d_resp_valid, resp_data);
        cyc();
        m_data_valid = 1'b0;
        m_data       = '0;
    endtask

    initial begin
        int k;
        logic [63:0] a1, a2, d1, d2;
        rstn = 1'b0;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        i_req_addr = '0; d_req_addr = '0;
        m_addr_ready = 1'b0; m_data_valid = 1'b0; m_data = '0; flush = 1'b0;

        // Reset state
        #3;
        check_val("rst_avalid", m_addr_valid, 1'b0);
        check_val("rst_addr", m_addr, 64'h0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_resp", {i_resp_valid, d_resp_valid}, 2'b00);
        check_val("rst_fault", {i_access_fault, d_access_fault}, 2'b00);
        cyc(); cyc();
        rstn = 1'b1;
        cyc();

        // Simultaneous I/D requests twice: order I, D, I, D
        for (int rnd = 0; rnd < 2; rnd++) begin
            a1 = 64'h1000 + 64'(rnd);
            d1 = 64'h2000 + 64'(rnd);
            pulse(1'b1, 1'b1, a1, d1, 1'b0);
            wait_issue(a1, k);
            do_handshake(0, a1);
            respond(2, 64'h11 + 64'(rnd), 1'b1, 1'b0);
            wait_issue(d1, k);
            check_val("idle_gap", k, 1);
            do_handshake(0, d1);
            respond(2, 64'h22 + 64'(rnd), 1'b0, 1'b1);
        end

        // Single ITLB request: latency N+2, data 0xCF three cycles later
        pulse(1'b1, 1'b0, 64'h8000_1000, 64'h0, 1'b0);
        wait_issue(64'h8000_1000, k);
        check_val("latency", k, 1);
        do_handshake(0, 64'h8000_1000);
        respond(3, 64'hCF, 1'b1, 1'b0);
        @(negedge clk);
        check_val("idle_busy", busy, 1'b0);
        cyc();

        // ITLB granted last, so a tie now goes to DTLB
        pulse(1'b1, 1'b1, 64'h3000, 64'h4000, 1'b0);
        wait_issue(64'h4000, k);
        do_handshake(0, 64'h4000);
        respond(1, 64'h33, 1'b0, 1'b1);
        wait_issue(64'h3000, k);
        do_handshake(0, 64'h3000);
        respond(1, 64'h44, 1'b1, 1'b0);

        // READY low for 5 cycles: address held and stable
        pulse(1'b0, 1'b1, 64'h0, 64'h5555_0000, 1'b0);
        wait_issue(64'h5555_0000, k);
        do_handshake(5, 64'h5555_0000);
        respond(1, 64'h55, 1'b0, 1'b1);

        // Overwrite of a pending slot while DTLB is being issued
        pulse(1'b0, 1'b1, 64'h0, 64'h6000, 1'b0);
        pulse(1'b1, 1'b0, 64'h7000, 64'h0, 1'b0);
        pulse(1'b1, 1'b0, 64'h7008, 64'h0, 1'b0);
        wait_issue(64'h6000, k);
        do_handshake(0, 64'h6000);
        respond(2, 64'h66, 1'b0, 1'b1);
        wait_issue(64'h7008, k);
        do_handshake(0, 64'h7008);
        respond(2, 64'h77, 1'b1, 1'b0);

        // FLUSH in WAIT with DTLB pending: no response, slot cleared
        pulse(1'b1, 1'b0, 64'h8100, 64'h0, 1'b0);
        wait_issue(64'h8100, k);
        do_handshake(0, 64'h8100);
        pulse(1'b0, 1'b1, 64'h0, 64'h8200, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check_val("flush_busy", busy, 1'b1);
        cyc();
        flush = 1'b0;
        respond(1, 64'h88, 1'b0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            check_val("flush_idle_busy", busy, 1'b0);
            check_val("flush_idle_avalid", m_addr_valid, 1'b0);
            cyc();
        end

        // Request coincident with FLUSH is discarded
        pulse(1'b1, 1'b0, 64'h8300, 64'h0, 1'b1);
        @(negedge clk);
        check_val("req_flush_busy", busy, 1'b0);
        cyc();

        // Reset during WAIT; late response ignored
        pulse(1'b1, 1'b0, 64'h9000, 64'h0, 1'b0);
        wait_issue(64'h9000, k);
        do_handshake(0, 64'h9000);
        rstn = 1'b0;
        #1;
        check_val("mid_rst_avalid", m_addr_valid, 1'b0);
        check_val("mid_rst_addr", m_addr, 64'h0);
        check_val("mid_rst_busy", busy, 1'b0);
        cyc();
        rstn = 1'b1;
        cyc();
        cyc();
        m_data_valid = 1'b1;
        m_data = 64'h99;
        @(negedge clk);
        check_val("late_resp", {i_resp_valid, d_resp_valid}, 2'b00);
        check_val("late_busy", busy, 1'b0);
        check_val("late_avalid", m_addr_valid, 1'b0);
        cyc();
        m_data_valid = 1'b0;
        m_data = '0;
        // Pointer back to ITLB after reset
        pulse(1'b1, 1'b1, 64'hA000, 64'hB000, 1'b0);
        wait_issue(64'hA000, k);
        do_handshake(0, 64'hA000);
        respond(1, 64'hAA, 1'b1, 1'b0);
        wait_issue(64'hB000, k);
        do_handshake(0, 64'hB000);
        respond(1, 64'hBB, 1'b0, 1'b1);

`ifdef PTW_TIMEOUT_EN
        // Timeout: fault pulse 16 cycles after the handshake
        pulse(1'b0, 1'b1, 64'h0, 64'hC000, 1'b0);
        wait_issue(64'hC000, k);
        do_handshake(0, 64'hC000);
        k = 1;
        @(negedge clk);
        while (!d_access_fault && k < 40) begin
            check_val("to_resp", {i_resp_valid, d_resp_valid}, 2'b00);
            cyc();
            @(negedge clk);
            k++;
        end
        check_val("to_fault_d", d_access_fault, 1'b1);
        check_val("to_fault_i", i_access_fault, 1'b0);
        check_val("to_cycles", k, 16);
        cyc();
        @(negedge clk);
        check_val("to_pulse_end", d_access_fault, 1'b0);
        cyc();
        m_data_valid = 1'b1;
        m_data = 64'hDD;
        @(negedge clk);
        check_val("drain_resp", {i_resp_valid, d_resp_valid}, 2'b00);
        cyc();
        m_data_valid = 1'b0;
        m_data = '0;
        pulse(1'b1, 1'b0, 64'hE000, 64'h0, 1'b0);
        wait_issue(64'hE000, k);
        do_handshake(0, 64'hE000);
        respond(2, 64'hEE, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
